// File: rtl/id_hazard_sb.sv
// -----------------------------------------------------------------------------
// id_hazard_sb -- ID-stage hazard scoreboard for the RV64 pipeline.
//
// Tracks the destination register of every in-flight instruction in a small
// shift register, one entry per downstream stage (entry 0 = EX, entry
// NUM_STAGES-1 = WB). From that it derives the data-hazard stall, the EX
// bubble and the per-source forwarding selects, and it counts stall cycles.
//
// Build option:
//   ID_HAZARD_FWD_EN defined   - forwarding network present; only a load in EX
//                                that feeds an ID source stalls (one cycle).
//   ID_HAZARD_FWD_EN undefined - no forwarding; fwd_sel_* tied to 0 and any
//                                match in entries 0..NUM_STAGES-2 stalls until
//                                the producer reaches WB (write-first RF).
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_valid                   ID holds a real instruction
//   id_rs1/id_rs2              source indices, id_rs1_used/id_rs2_used
//   id_rd, id_rd_we            destination index and write enable
//   id_is_load                 ID instruction is a load
//   ex_flush                   redirect: ID instruction is killed
//   pipe_hold                  global freeze
//   stall_id                   hold IF/ID this cycle
//   bubble_ex                  insert a NOP into EX this cycle
//   fwd_sel_rs1/fwd_sel_rs2    0 = register file, k = forward from stage k-1
//   stall_cnt                  saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module id_hazard_sb #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_STAGES     = 3,
  parameter int SEL_WIDTH      = 3,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_rd_we,
  input  logic                      id_is_load,
  input  logic                      ex_flush,
  input  logic                      pipe_hold,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic [SEL_WIDTH-1:0]      fwd_sel_rs1,
  output logic [SEL_WIDTH-1:0]      fwd_sel_rs2,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  // Scoreboard entries
  logic [NUM_STAGES-1:0]     valid_q, valid_d;
  logic [NUM_STAGES-1:0]     load_q,  load_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q [NUM_STAGES];
  logic [REG_ADDR_WIDTH-1:0] rd_d [NUM_STAGES];
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  // Per-source "this source is live": x0 is hard-wired zero and never matches.
  logic src1_live, src2_live;
  assign src1_live = id_valid & id_rs1_used & (id_rs1 != '0);
  assign src2_live = id_valid & id_rs2_used & (id_rs2 != '0);

  logic [NUM_STAGES-1:0] match_rs1, match_rs2;

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_match
      assign match_rs1[gi] = src1_live & valid_q[gi] & (rd_q[gi] == id_rs1);
      assign match_rs2[gi] = src2_live & valid_q[gi] & (rd_q[gi] == id_rs2);
    end
  endgenerate

  logic hazard;

`ifdef ID_HAZARD_FWD_EN
  // Only a load sitting in EX cannot be forwarded yet; everything else can.
  assign hazard = (match_rs1[0] | match_rs2[0]) & load_q[0];

  // Priority encoder: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_sel_rs1 = '0;
    fwd_sel_rs2 = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (match_rs1[i]) fwd_sel_rs1 = SEL_WIDTH'(i + 1);
      if (match_rs2[i]) fwd_sel_rs2 = SEL_WIDTH'(i + 1);
    end
  end

  logic unused_sb;
  assign unused_sb = load_q[NUM_STAGES-1];
`else
  // Without forwarding, wait until the producer reaches WB; the register file
  // is write-first so a match in the WB entry is already safe to read.
  assign hazard = |(match_rs1[NUM_STAGES-2:0] | match_rs2[NUM_STAGES-2:0]);

  assign fwd_sel_rs1 = '0;
  assign fwd_sel_rs2 = '0;

  logic unused_sb;
  assign unused_sb = ^{load_q, match_rs1[NUM_STAGES-1], match_rs2[NUM_STAGES-1]};
`endif

  // A flushed ID instruction is dead, so it can never cause a stall.
  assign stall_id  = hazard & id_valid & ~ex_flush;
  assign bubble_ex = stall_id & ~pipe_hold;
  assign stall_cnt = cnt_q;

  // Next-state: shift one stage per unfrozen cycle.
  always_comb begin
    valid_d = valid_q;
    load_d  = load_q;
    for (int i = 0; i < NUM_STAGES; i++) rd_d[i] = rd_q[i];
    cnt_d   = cnt_q;

    if (!pipe_hold) begin
      // A stalled or flushed instruction enters EX as a bubble.
      valid_d[0] = id_valid & id_rd_we & (id_rd != '0) & ~stall_id & ~ex_flush;
      load_d[0]  = id_is_load;
      rd_d[0]    = id_rd;
      for (int i = 1; i < NUM_STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        load_d[i]  = load_q[i-1];
        rd_d[i]    = rd_q[i-1];
      end
      if (stall_id && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      load_q  <= '0;
      for (int i = 0; i < NUM_STAGES; i++) rd_q[i] <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      load_q  <= load_d;
      for (int i = 0; i < NUM_STAGES; i++) rd_q[i] <= rd_d[i];
      cnt_q   <= cnt_d;
    end
  end

endmodule
